// File: rtl/klein_mm_master.sv
// Initiator-side sequencer for the KLEIN register slave: loads key/block, pulses
// CTRL, polls STATUS with a bounded retry count and reads the 64-bit result back.
module klein_mm_master #(
  parameter int POLL_LIMIT = 1024,
  parameter int SETTLE     = 2
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        istart,
  input  logic        ireuse_key,
  input  logic        iencdec,
  input  logic [63:0] ikey,
  input  logic [63:0] iblock,
  output logic        obusy,
  output logic        odone,
  output logic        oerror,
  output logic [63:0] oresult,
  output logic        ocs,
  output logic        owe,
  output logic [7:0]  oaddress,
  output logic [31:0] owrite_data,
  input  logic [31:0] iread_data
);

  localparam int CNT_W = $clog2(POLL_LIMIT + SETTLE + 1) + 1;
  localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(POLL_LIMIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [7:0] A_CTRL    = 8'h00;
  localparam logic [7:0] A_CONF    = 8'h01;
  localparam logic [7:0] A_STATUS  = 8'h02;
  localparam logic [7:0] A_KEY0    = 8'h10;
  localparam logic [7:0] A_KEY1    = 8'h11;
  localparam logic [7:0] A_BLOCK0  = 8'h20;
  localparam logic [7:0] A_BLOCK1  = 8'h21;
  localparam logic [7:0] A_RESULT0 = 8'h30;
  localparam logic [7:0] A_RESULT1 = 8'h31;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY0, S_WR_KEY1, S_WR_INIT, S_SETTLE_I, S_POLL_I,
    S_WR_BLK0, S_WR_BLK1, S_WR_CONF, S_WR_NEXT, S_SETTLE_N, S_POLL_N,
    S_RD_RES0, S_RD_RES1, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      key_q, key_d;
  logic [63:0]      block_q, block_d;
  logic             encdec_q, encdec_d;
  logic             timeout;

  logic             obusy_q, obusy_d;
  logic             odone_q, odone_d;
  logic             oerror_q, oerror_d;
  logic [63:0]      oresult_q, oresult_d;
  logic             ocs_q, ocs_d;
  logic             owe_q, owe_d;
  logic [7:0]       oaddress_q, oaddress_d;
  logic [31:0]      owrite_data_q, owrite_data_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    block_d   = block_q;
    encdec_d  = encdec_q;
    oresult_d = oresult_q;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (istart) begin
          key_d    = ikey;
          block_d  = iblock;
          encdec_d = iencdec;
          state_d  = ireuse_key ? S_WR_BLK0 : S_WR_KEY0;
        end
      end
      S_WR_KEY0: state_d = S_WR_KEY1;
      S_WR_KEY1: state_d = S_WR_INIT;
      S_WR_INIT: begin
        state_d = S_SETTLE_I;
        cnt_d   = '0;
      end
      S_SETTLE_I: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_POLL_I;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_POLL_I: begin
        if (iread_data[0]) begin
          state_d = S_WR_BLK0;
        end else if (cnt_q == POLL_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WR_BLK0: state_d = S_WR_BLK1;
      S_WR_BLK1: state_d = S_WR_CONF;
      S_WR_CONF: state_d = S_WR_NEXT;
      S_WR_NEXT: begin
        state_d = S_SETTLE_N;
        cnt_d   = '0;
      end
      S_SETTLE_N: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_POLL_N;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_POLL_N: begin
        if (iread_data[1] && iread_data[0]) begin
          state_d = S_RD_RES0;
        end else if (cnt_q == POLL_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RD_RES0: begin
        oresult_d[63:32] = iread_data;
        state_d          = S_RD_RES1;
      end
      S_RD_RES1: begin
        oresult_d[31:0] = iread_data;
        state_d         = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up
  // with the state cycle; key_d/block_d make first-cycle data valid too.
  always_comb begin
    ocs_d         = 1'b0;
    owe_d         = 1'b0;
    oaddress_d    = 8'h00;
    owrite_data_d = 32'h0;
    case (state_d)
      S_WR_KEY0: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_KEY0; owrite_data_d = key_d[63:32];
      end
      S_WR_KEY1: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_KEY1; owrite_data_d = key_d[31:0];
      end
      S_WR_INIT: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_CTRL; owrite_data_d = 32'h1;
      end
      S_WR_BLK0: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_BLOCK0; owrite_data_d = block_d[63:32];
      end
      S_WR_BLK1: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_BLOCK1; owrite_data_d = block_d[31:0];
      end
      S_WR_CONF: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_CONF; owrite_data_d = {31'b0, encdec_d};
      end
      S_WR_NEXT: begin
        ocs_d = 1'b1; owe_d = 1'b1; oaddress_d = A_CTRL; owrite_data_d = 32'h2;
      end
      S_POLL_I, S_POLL_N: begin
        ocs_d = 1'b1; oaddress_d = A_STATUS;
      end
      S_RD_RES0: begin
        ocs_d = 1'b1; oaddress_d = A_RESULT0;
      end
      S_RD_RES1: begin
        ocs_d = 1'b1; oaddress_d = A_RESULT1;
      end
      default: begin
        ocs_d = 1'b0;
      end
    endcase
    obusy_d  = (state_d != S_IDLE);
    odone_d  = (state_d == S_DONE);
    oerror_d = timeout;
  end

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      obusy_q       <= 1'b0;
      odone_q       <= 1'b0;
      oerror_q      <= 1'b0;
      oresult_q     <= 64'h0;
      ocs_q         <= 1'b0;
      owe_q         <= 1'b0;
      oaddress_q    <= 8'h00;
      owrite_data_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      obusy_q       <= obusy_d;
      odone_q       <= odone_d;
      oerror_q      <= oerror_d;
      oresult_q     <= oresult_d;
      ocs_q         <= ocs_d;
      owe_q         <= owe_d;
      oaddress_q    <= oaddress_d;
      owrite_data_q <= owrite_data_d;
    end
  end

  // Operand captures need no reset: they are only read after an accepted start.
  always_ff @(posedge iclk) begin
    key_q    <= key_d;
    block_q  <= block_d;
    encdec_q <= encdec_d;
  end

  assign obusy       = obusy_q;
  assign odone       = odone_q;
  assign oerror      = oerror_q;
  assign oresult     = oresult_q;
  assign ocs         = ocs_q;
  assign owe         = owe_q;
  assign oaddress    = oaddress_q;
  assign owrite_data = owrite_data_q;

endmodule
